// File: rtl/decode_stage.sv
// Decode stage: field decode, scalar register file, jump/branch resolution.
// Drives the fetch redirect port and squashes the wrong-path slot after it.
module decode_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int PC_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           instruction,
    input  logic                  wbEn,
    input  logic [3:0]            wbAddr,
    input  logic [DATA_WIDTH-1:0] wbData,
    output logic                  pcWrEn,
    output logic [PC_WIDTH-1:0]   newPc,
    output logic                  exValid,
    output logic [3:0]            exOp,
    output logic [3:0]            exRd,
    output logic [DATA_WIDTH-1:0] exA,
    output logic [DATA_WIDTH-1:0] exB,
    output logic [7:0]            exImm
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_BNZ = 4'hE;
    localparam logic [3:0] OP_JMP = 4'hF;

    logic [DATA_WIDTH-1:0] regs [16];

    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] imm;

    logic [DATA_WIDTH-1:0] vala;
    logic [DATA_WIDTH-1:0] valb;
    logic [DATA_WIDTH-1:0] vald;

    logic squash;
    logic jump;
    logic pass;
    logic take;
    logic issue;

    assign op  = instruction[15:12];
    assign rd  = instruction[11:8];
    assign rs1 = instruction[7:4];
    assign rs2 = instruction[3:0];
    assign imm = instruction[7:0];

    // The slot right after a taken redirect is wrong-path.
    assign squash = pcWrEn;

    // Register reads: r0 is hardwired to zero, write-back is bypassed.
    always_comb begin
        vala = '0;
        valb = '0;
        vald = '0;
        if (rs1 != 4'd0) vala = (wbEn && wbAddr == rs1) ? wbData : regs[rs1];
        if (rs2 != 4'd0) valb = (wbEn && wbAddr == rs2) ? wbData : regs[rs2];
        if (rd  != 4'd0) vald = (wbEn && wbAddr == rd)  ? wbData : regs[rd];
    end

    // Opcode class: redirect, drop, or forward to EX.
    always_comb begin
        jump = 1'b0;
        pass = 1'b0;
        unique case (1'b1)
            op == OP_JMP: jump = 1'b1;
            op == OP_BNZ: jump = |vald;
            op == OP_NOP: jump = 1'b0;
            default:      pass = 1'b1;
        endcase
    end

    assign take  = jump && !squash;
    assign issue = pass && !squash;

    // Scalar register file with write-back port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (wbEn && wbAddr != 4'd0) begin
            regs[wbAddr] <= wbData;
        end
    end

    // ID/EX slot and single-cycle redirect pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcWrEn  <= 1'b0;
            newPc   <= '0;
            exValid <= 1'b0;
            exOp    <= '0;
            exRd    <= '0;
            exA     <= '0;
            exB     <= '0;
            exImm   <= '0;
        end else begin
            pcWrEn <= take;
            if (take) newPc <= PC_WIDTH'(imm);
            exValid <= issue;
            exOp    <= issue ? op   : '0;
            exRd    <= issue ? rd   : '0;
            exA     <= issue ? vala : '0;
            exB     <= issue ? valb : '0;
            exImm   <= issue ? imm  : '0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against a behavioural model.
// Directed test-plan sequences first, then random traffic.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instruction;
    logic        wbEn;
    logic [3:0]  wbAddr;
    logic [15:0] wbData;
    logic        pcWrEn;
    logic [7:0]  newPc;
    logic        exValid;
    logic [3:0]  exOp;
    logic [3:0]  exRd;
    logic [15:0] exA;
    logic [15:0] exB;
    logic [7:0]  exImm;

    int checks = 0;
    int errors = 0;

    logic [15:0] mregs [16];
    logic        mpc   = 1'b0;
    logic [7:0]  mnpc  = 8'h00;

    decode_stage dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
        .pcWrEn(pcWrEn), .newPc(newPc), .exValid(exValid),
        .exOp(exOp), .exRd(exRd), .exA(exA), .exB(exB), .exImm(exImm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rdm(input logic [3:0] a, input logic we,
                                        input logic [3:0] wa, input logic [15:0] wd);
        if (a == 0) return 16'h0;
        if (we && wa == a) return wd;
        return mregs[a];
    endfunction

    // One clock: drive inputs, predict, advance, compare every output.
    task automatic step(input logic r, input logic [15:0] ins, input logic we,
                        input logic [3:0] wa, input logic [15:0] wd);
        logic        ev;
        logic [3:0]  eop, erd;
        logic [15:0] ea, eb;
        logic [7:0]  eimm;
        logic        epc;
        logic [7:0]  enpc;
        logic [3:0]  op;
        logic        redirect;
        rst = r; instruction = ins; wbEn = we; wbAddr = wa; wbData = wd;
        op = ins[15:12];
        ev = 0; eop = 0; erd = 0; ea = 0; eb = 0; eimm = 0;
        epc = 0; enpc = mnpc;
        if (r) begin
            enpc = 0;
            for (int i = 0; i < 16; i++) mregs[i] = 0;
        end else begin
            redirect = !mpc && (op == 4'hF ||
                       (op == 4'hE && rdm(ins[11:8], we, wa, wd) != 0));
            if (redirect) begin
                epc = 1; enpc = ins[7:0];
            end
            if (!mpc && op != 4'h0 && op != 4'hE && op != 4'hF) begin
                ev = 1; eop = op; erd = ins[11:8]; eimm = ins[7:0];
                ea = rdm(ins[7:4], we, wa, wd);
                eb = rdm(ins[3:0], we, wa, wd);
            end
            if (we && wa != 0) mregs[wa] = wd;
        end
        mpc = epc; mnpc = enpc;
        @(posedge clk); #1;
        check("pcWrEn", 32'(pcWrEn), 32'(epc));
        check("newPc", 32'(newPc), 32'(enpc));
        check("exValid", 32'(exValid), 32'(ev));
        check("exOp", 32'(exOp), 32'(eop));
        check("exRd", 32'(exRd), 32'(erd));
        check("exA", 32'(exA), 32'(ea));
        check("exB", 32'(exB), 32'(eb));
        check("exImm", 32'(exImm), 32'(eimm));
    endtask

    initial begin
        logic [15:0] ins;
        rst = 1; instruction = 0; wbEn = 0; wbAddr = 0; wbData = 0;
        for (int i = 0; i < 16; i++) mregs[i] = 0;

        step(1, 16'h1234, 0, 0, 0);
        step(1, 16'h1234, 0, 0, 0);
        check("rst_exValid", 32'(exValid), 32'd0);
        step(0, 16'h1234, 0, 0, 0);
        check("rel_exOp", 32'(exOp), 32'd1);
        check("rel_exRd", 32'(exRd), 32'd2);

        step(0, 16'h0000, 1, 3, 16'h00AA);
        step(0, 16'h0000, 1, 4, 16'h0055);
        step(0, 16'h1534, 0, 0, 0);
        check("rd_exA", 32'(exA), 32'h00AA);
        step(0, 16'h0000, 1, 0, 16'hFFFF);
        step(0, 16'h1100, 0, 0, 0);
        check("r0_exA", 32'(exA), 32'h0);

        step(0, 16'h2130, 1, 3, 16'h7777);
        check("byp_exA", 32'(exA), 32'h7777);

        step(0, 16'hF010, 0, 0, 0);
        check("jmp_newPc", 32'(newPc), 32'h10);
        step(0, 16'hF020, 0, 0, 0);
        check("sq_pcWrEn", 32'(pcWrEn), 32'd0);
        step(0, 16'h7007, 0, 0, 0);
        check("tgt_exOp", 32'(exOp), 32'd7);

        step(0, 16'hE240, 0, 0, 0);
        check("bnz0_pcWrEn", 32'(pcWrEn), 32'd0);
        step(0, 16'h0000, 1, 2, 16'h0001);
        step(0, 16'hE240, 0, 0, 0);
        check("bnz1_newPc", 32'(newPc), 32'h40);
        step(0, 16'h0000, 0, 0, 0);
        step(0, 16'hE240, 1, 2, 16'h0000);
        step(0, 16'hE240, 1, 2, 16'h0009);

        step(0, 16'h0000, 0, 0, 0);
        step(0, 16'hF050, 0, 0, 0);
        step(1, 16'h1020, 0, 0, 0);
        check("rstmid_pcWrEn", 32'(pcWrEn), 32'd0);
        step(0, 16'h1020, 0, 0, 0);
        check("rstmid_r2", 32'(exA), 32'h0);

        for (int n = 0; n < 600; n++) begin
            ins = 16'($urandom);
            case ($urandom_range(0, 5))
                0: ins[15:12] = 4'hF;
                1: ins[15:12] = 4'hE;
                2: ins[15:12] = 4'h0;
                default: ;
            endcase
            step(($urandom_range(0, 60) == 0), ins, 1'($urandom),
                 4'($urandom), ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage of the SIMD processor. Sits directly downstream of fetch.
- Each cycle it takes the 16-bit instruction word from fetch, decodes the fields and reads the scalar register file, then registers the result into the ID/EX outputs.
- Resolves jumps and branches and drives fetch's pcWrEn/newPc redirect port. Squashes the one wrong-path instruction that follows a taken redirect.
- Owns the 16-entry scalar register file and its write-back port.

Parameters:
- DATA_WIDTH, 16, scalar register and operand width.
- PC_WIDTH, 8, program counter width; must match fetch newPc.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instruction  in  16  instruction word from fetch for the current PC
- wbEn  in  1  register-file write enable from write-back
- wbAddr  in  4  write-back destination register
- wbData  in  DATA_WIDTH  write-back data
- pcWrEn  out  1  redirect request to fetch, one-cycle pulse
- newPc  out  PC_WIDTH  redirect target to fetch
- exValid  out  1  ID/EX slot holds a real instruction
- exOp  out  4  opcode
- exRd  out  4  destination register
- exA  out  DATA_WIDTH  value of reg[rs1]
- exB  out  DATA_WIDTH  value of reg[rs2]
- exImm  out  8  instruction[7:0]

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Instruction fields: op=[15:12], rd=[11:8], rs1=[7:4], rs2=[3:0], imm8=[7:0].
- Special opcodes:
  - 4'h0 = NOP.
  - 4'hF = JMP imm8.
  - 4'hE = BNZ: jump to imm8 if reg[rd] != 0.
  - All other opcodes pass through to EX unchanged.
- Register file:
  - 16 x DATA_WIDTH. r0 always reads 0; writes to r0 are ignored.
  - Write occurs on the rising edge when wbEn=1.
  - Reads are combinational with write-first bypass: if wbEn=1 and wbAddr equals a nonzero read address, that read returns wbData in the same cycle.
  - All registers clear to 0 on reset.
- ID/EX register: latency 1 cycle. Fields sampled from instruction on the edge appear on the outputs after that edge.
- exValid:
  - exValid=0 when the captured op is NOP, JMP or BNZ, or when the instruction is squashed.
  - When exValid=0, exOp, exRd, exA, exB and exImm are forced to 0.
- Redirect:
  - On an edge where the captured instruction is JMP, or BNZ with bypassed reg[rd] != 0, and the stage is not squashing, pcWrEn becomes 1 and newPc = imm8 for exactly one cycle.
  - Otherwise pcWrEn=0 and newPc holds its last value.
- Squash:
  - On an edge where pcWrEn is currently 1, the incoming instruction is wrong-path. It is treated as a bubble: exValid=0, no redirect even if it is JMP/BNZ.
  - Net cost of a taken redirect is one bubble; the target instruction is captured on the following edge.
- Back-to-back redirects: a JMP arriving in the squash cycle is discarded; no double pulse is possible.
- Reset:
  - pcWrEn=0, newPc=0, exValid=0, all ex* outputs=0, register file cleared, squash state cleared.
  - Reset asserted mid-redirect (pcWrEn=1) clears pcWrEn on that edge.
- Simultaneous write-back and read of the same register in the cycle a BNZ is captured: the branch decision uses wbData (bypass).

Test Plan:
- Reset: rst=1 for 2 edges with instruction=16'h1234 -> pcWrEn=0, newPc=0, exValid=0, exA=exB=0; release -> next edge exValid=1, exOp=1, exRd=2, exImm=8'h34.
- Register read: write r3=16'h00AA and r4=16'h0055 via wbEn, then instruction=16'h1534 -> exA=16'h00AA, exB=16'h0055, exRd=5. Writing r0=16'hFFFF then reading r0 -> 0.
- Bypass: wbEn=1, wbAddr=3, wbData=16'h7777 in the same cycle instruction=16'h2130 -> exA=16'h7777 after the edge.
- JMP: instruction=16'hF010 -> next cycle pcWrEn=1, newPc=8'h10, exValid=0. Following instruction=16'hF020 (wrong path) -> exValid=0, pcWrEn returns to 0, no second pulse. Then 16'h7007 -> exValid=1, exOp=7.
- BNZ: with r2=0, instruction=16'hE240 -> pcWrEn stays 0. With r2=1, same word -> pcWrEn=1, newPc=8'h40 for exactly one cycle.
- Reset mid-redirect: assert rst in the cycle pcWrEn=1 -> after the edge pcWrEn=0, newPc=0, exValid=0, and r2 reads 0.
